rv32i_decode_stage: RTL and testbench
=====================================

Name: rv32i_decode_stage

Overview:
- ID stage of the RV32I pipeline. Sits between the IF/ID register and the execute stage.
- Decodes the instruction and drives the register-file read addresses. Captures the combinational register-file read data, the decoded controls and the generated immediate into the ID/EX pipeline register.
- Detects load-use hazards and inserts one bubble per hazard. Supports a synchronous flush on taken branch or jump.

Parameters:
- XLEN, 32, datapath and immediate width.
- RESET_PC, 32'h0000_0000, value driven on ex_pc while ex_valid=0 after reset.

Ports:
- clk  in  1  rising-edge clock for the ID/EX register.
- rst  in  1  reset: synchronous, active-high.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_ready  out  1  ID accepts the instruction this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  PC of if_instr.
- rf_raddr1  out  5  register-file read address 1 (instr[19:15]).
- rf_raddr2  out  5  register-file read address 2 (instr[24:20]).
- rf_rdata1  in  XLEN  combinational read data 1.
- rf_rdata2  in  XLEN  combinational read data 2.
- flush  in  1  kill the instruction currently in ID, and any bubble decision.
- ex_ready  in  1  EX consumes the ID/EX contents this cycle.
- ex_valid  out  1  ID/EX register holds a valid op.
- ex_pc  out  XLEN  PC of the op.
- ex_rs1_val  out  XLEN  captured rf_rdata1.
- ex_rs2_val  out  XLEN  captured rf_rdata2.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_rs1  out  5  source register 1 index (for forwarding).
- ex_rs2  out  5  source register 2 index (for forwarding).
- ex_rd  out  5  destination register index.
- ex_op  out  4  op_class_t opcode class.
- ex_funct3  out  3  instr[14:12].
- ex_funct7b5  out  1  instr[30].
- ex_reg_write  out  1  op writes rd.
- ex_mem_read  out  1  op is a load.
- ex_mem_write  out  1  op is a store.
- ex_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (rst=1 at posedge): ex_valid=0, ex_pc=RESET_PC, all other ex_* outputs = 0. Reset has priority over flush, hazard and advance.
- rf_raddr1/2 are driven combinationally from if_instr regardless of if_valid.
- The register file updates on the falling clock edge. WB-to-ID bypass is therefore not this block's job: rf_rdata is sampled as-is.
- Latency: 1 cycle, IF/ID to ID/EX.
- advance = ~ex_valid | ex_ready.
- hazard = ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == rs1 & uses_rs1) | (ex_rd == rs2 & uses_rs2)).
- uses_rs1 is set for OP, OP_IMM, LOAD, STORE, BRANCH and JALR. uses_rs2 is set for OP, STORE and BRANCH only.
- if_ready = flush | (advance & ~hazard).
- Next state of the ID/EX register, in priority order:
  - flush: ex_valid <= 0, and the IF/ID instruction is consumed and discarded.
  - advance & hazard: ex_valid <= 0 (bubble), and the IF/ID instruction is held.
  - advance & if_valid: capture all fields, ex_valid <= 1.
  - advance & ~if_valid: ex_valid <= 0.
  - ~advance: hold all ex_* outputs unchanged.
- A hazard clears after exactly one bubble, because the load moves to EX. A hazard pending with ex_ready=0 simply holds the register.
- Immediates:
  - I: instr[31:20], sign-extended.
  - S: {instr[31:25], instr[11:7]}, sign-extended.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, sign-extended.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, sign-extended.
  - OP / illegal: 0.
- ex_reg_write = 1 for OP, OP_IMM, LOAD, LUI, AUIPC, JAL and JALR, and is forced to 0 when rd = 0.
- Unknown opcode: ex_op = OP_ILLEGAL, ex_illegal = 1, and reg_write, mem_read and mem_write are all 0. The op still flows with ex_valid = 1 so that EX can trap.
- While ex_valid = 0, the ex_* control bits (reg_write, mem_read, mem_write) are 0. Data fields are don't-care.
- A flush asserted in the same cycle as a hazard discards the instruction. No stall results.

Decomposition:
- Package rv32i_pkg holds:
  - op_class_t enum: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP_ILLEGAL.
  - RV32I 7-bit opcode constants.
  - imm_fmt_t enum: I, S, B, U, J, NONE.
- One sub-module: rv32i_imm_gen, purely combinational (instr, fmt -> imm).
- Opcode decode, hazard detection and the ID/EX register stay in the top module.

Test Plan:
- addi x1,x0,5 (0x00500093), pc=0x100, ex_ready=1 -> next cycle ex_valid=1, ex_op=OP_IMM, ex_imm=5, ex_rd=1, ex_reg_write=1, ex_pc=0x100.
- lw x2,0(x1) (0x0000A103) followed by add x3,x2,x1 (0x001101B3) -> if_ready=0 for one cycle, one bubble (ex_valid=0), then the add appears with ex_rs1=2, ex_rs2=1.
- beq x0,x0,-8 (0xFE000CE3) -> ex_imm=0xFFFFFFF8, ex_reg_write=0. Then sw x3,4(x0) (0x00302223) -> ex_imm=4, ex_mem_write=1, ex_reg_write=0.
- ex_ready=0 for 3 cycles with if_valid=1 -> ex_* stable, if_ready=0. On release, the next instruction is captured in 1 cycle.
- flush=1 during a hazard cycle -> if_ready=1, next ex_valid=0, and no further stall.
- Instruction 0x0000007F -> ex_illegal=1, ex_valid=1, all write controls 0. rst=1 mid-stream -> next cycle ex_valid=0, ex_pc=RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: opcode-class and immediate-format enums,
// base opcode constants, and the per-opcode control decode.
package rv32i_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned INSTR_W = 32;

    typedef enum logic [3:0] {
        OP         = 4'd0,
        OP_IMM     = 4'd1,
        LOAD       = 4'd2,
        STORE      = 4'd3,
        BRANCH     = 4'd4,
        JAL        = 4'd5,
        JALR       = 4'd6,
        LUI        = 4'd7,
        AUIPC      = 4'd8,
        OP_ILLEGAL = 4'd9
    } op_class_t;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        op_class_t op;
        imm_fmt_t  fmt;
        logic      uses_rs1;
        logic      uses_rs2;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      illegal;
    } dec_t;

    // Opcode -> class, immediate format, operand usage and write controls.
    // reg_write here ignores rd==0; the caller masks that.
    function automatic dec_t decode_opcode(input logic [6:0] opc);
        dec_t d;
        d         = '0;
        d.op      = OP_ILLEGAL;
        d.fmt     = FMT_NONE;
        d.illegal = 1'b1;
        case (opc)
            OPC_OP:     begin d = '0; d.op = OP;     d.fmt = FMT_NONE; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.reg_write = 1'b1; end
            OPC_OP_IMM: begin d = '0; d.op = OP_IMM; d.fmt = FMT_I;    d.uses_rs1 = 1'b1; d.reg_write = 1'b1; end
            OPC_LOAD:   begin d = '0; d.op = LOAD;   d.fmt = FMT_I;    d.uses_rs1 = 1'b1; d.reg_write = 1'b1; d.mem_read = 1'b1; end
            OPC_STORE:  begin d = '0; d.op = STORE;  d.fmt = FMT_S;    d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.mem_write = 1'b1; end
            OPC_BRANCH: begin d = '0; d.op = BRANCH; d.fmt = FMT_B;    d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
            OPC_JAL:    begin d = '0; d.op = JAL;    d.fmt = FMT_J;    d.reg_write = 1'b1; end
            OPC_JALR:   begin d = '0; d.op = JALR;   d.fmt = FMT_I;    d.uses_rs1 = 1'b1; d.reg_write = 1'b1; end
            OPC_LUI:    begin d = '0; d.op = LUI;    d.fmt = FMT_U;    d.reg_write = 1'b1; end
            OPC_AUIPC:  begin d = '0; d.op = AUIPC;  d.fmt = FMT_U;    d.reg_write = 1'b1; end
            default:    ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// ID-stage bus: IF/ID handshake, register-file read port, flush and the
// ID/EX register outputs. master = decode stage, slave = its neighbours.
interface rv32i_decode_stage_if #(parameter int unsigned XLEN = 32);
    import rv32i_pkg::*;

    logic                if_valid;
    logic                if_ready;
    logic [INSTR_W-1:0]  if_instr;
    logic [XLEN-1:0]     if_pc;
    logic [REG_AW-1:0]   rf_raddr1;
    logic [REG_AW-1:0]   rf_raddr2;
    logic [XLEN-1:0]     rf_rdata1;
    logic [XLEN-1:0]     rf_rdata2;
    logic                flush;
    logic                ex_ready;
    logic                ex_valid;
    logic [XLEN-1:0]     ex_pc;
    logic [XLEN-1:0]     ex_rs1_val;
    logic [XLEN-1:0]     ex_rs2_val;
    logic [XLEN-1:0]     ex_imm;
    logic [REG_AW-1:0]   ex_rs1;
    logic [REG_AW-1:0]   ex_rs2;
    logic [REG_AW-1:0]   ex_rd;
    op_class_t           ex_op;
    logic [2:0]          ex_funct3;
    logic                ex_funct7b5;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_illegal;

    modport master (
        input  if_valid, if_instr, if_pc, rf_rdata1, rf_rdata2, flush, ex_ready,
        output if_ready, rf_raddr1, rf_raddr2,
        output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd,
        output ex_op, ex_funct3, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal
    );

    modport slave (
        output if_valid, if_instr, if_pc, rf_rdata1, rf_rdata2, flush, ex_ready,
        input  if_ready, rf_raddr1, rf_raddr2,
        input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1, ex_rs2, ex_rd,
        input  ex_op, ex_funct3, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal
    );

endinterface

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate generator.
// Ports: i_instr  instruction bits [31:7] (opcode not needed)
//        i_fmt    immediate format selected by the opcode decode
//        o_imm    sign-extended (U: zero-filled low bits) immediate
module rv32i_imm_gen
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     i_instr,
    input  imm_fmt_t        i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [20:0] w_imm_j;

    assign w_imm_i = i_instr[31:20];
    assign w_imm_s = {i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'b0};
    assign w_imm_j = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    // Signed sources make the width casts sign-extend to XLEN.
    always_comb begin
        o_imm = '0;
        case (i_fmt)
            FMT_I:   o_imm = XLEN'(w_imm_i);
            FMT_S:   o_imm = XLEN'(w_imm_s);
            FMT_B:   o_imm = XLEN'(w_imm_b);
            FMT_U:   o_imm = XLEN'(w_imm_u);
            FMT_J:   o_imm = XLEN'(w_imm_j);
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I ID stage: decodes the IF/ID instruction, drives the register-file
// read addresses, detects load-use hazards (one bubble each) and owns the
// ID/EX pipeline register, with synchronous flush.
// Ports: clk  rising-edge clock
//        rst  synchronous active-high reset
//        bus  rv32i_decode_stage_if.master (IF/ID handshake, RF read port,
//             flush, ID/EX outputs)
module rv32i_decode_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    rv32i_decode_stage_if.master  bus
);

    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rd;
    dec_t              w_dec;
    logic [XLEN-1:0]   w_imm;
    logic              w_advance;
    logic              w_hazard;
    logic              w_reg_write;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_val;
    logic [XLEN-1:0]   r_rs2_val;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    op_class_t         r_op;
    logic [2:0]        r_funct3;
    logic              r_funct7b5;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_illegal;

    // Field extraction and decode; RF addresses ignore if_valid.
    assign w_rs1   = bus.if_instr[19:15];
    assign w_rs2   = bus.if_instr[24:20];
    assign w_rd    = bus.if_instr[11:7];
    assign w_dec   = decode_opcode(bus.if_instr[6:0]);
    assign w_reg_write = w_dec.reg_write & (w_rd != '0);

    assign bus.rf_raddr1 = w_rs1;
    assign bus.rf_raddr2 = w_rs2;

    rv32i_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (bus.if_instr[31:7]),
        .i_fmt   (w_dec.fmt),
        .o_imm   (w_imm)
    );

    // A load in EX whose rd feeds an operand of the ID instruction.
    assign w_advance = ~r_valid | bus.ex_ready;
    assign w_hazard  = r_valid & r_mem_read & (r_rd != '0) &
                       (((r_rd == w_rs1) & w_dec.uses_rs1) |
                        ((r_rd == w_rs2) & w_dec.uses_rs2));

    // Flush always consumes (and discards) the IF/ID instruction.
    assign bus.if_ready = bus.flush | (w_advance & ~w_hazard);

    // ID/EX register: reset > flush > bubble/empty/capture > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_pc        <= RESET_PC;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_op        <= OP;
            r_funct3    <= '0;
            r_funct7b5  <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (bus.flush || (w_advance && (w_hazard || !bus.if_valid))) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_advance) begin
            r_valid     <= 1'b1;
            r_pc        <= bus.if_pc;
            r_rs1_val   <= bus.rf_rdata1;
            r_rs2_val   <= bus.rf_rdata2;
            r_imm       <= w_imm;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_op        <= w_dec.op;
            r_funct3    <= bus.if_instr[14:12];
            r_funct7b5  <= bus.if_instr[30];
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_dec.mem_read;
            r_mem_write <= w_dec.mem_write;
            r_illegal   <= w_dec.illegal;
        end
    end

    assign bus.ex_valid     = r_valid;
    assign bus.ex_pc        = r_pc;
    assign bus.ex_rs1_val   = r_rs1_val;
    assign bus.ex_rs2_val   = r_rs2_val;
    assign bus.ex_imm       = r_imm;
    assign bus.ex_rs1       = r_rs1;
    assign bus.ex_rs2       = r_rs2;
    assign bus.ex_rd        = r_rd;
    assign bus.ex_op        = r_op;
    assign bus.ex_funct3    = r_funct3;
    assign bus.ex_funct7b5  = r_funct7b5;
    assign bus.ex_reg_write = r_reg_write;
    assign bus.ex_mem_read  = r_mem_read;
    assign bus.ex_mem_write = r_mem_write;
    assign bus.ex_illegal   = r_illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed scoreboard bench for rv32i_decode_stage.
module tb_rv32i_decode_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0040;
    localparam int K_CAP  = 0;
    localparam int K_HOLD = 1;
    localparam int K_BUB  = 2;
    localparam int K_RST  = 3;

    typedef struct {
        logic        valid;
        logic        full;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t last_e;

    always #5 clk = ~clk;

    rv32i_decode_stage_if #(.XLEN(32)) bus ();

    rv32i_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file stand-in: data encodes the address so captures are traceable.
    assign bus.rf_rdata1 = 32'hA000_0000 | 32'(bus.rf_raddr1);
    assign bus.rf_rdata2 = 32'hB000_0000 | 32'(bus.rf_raddr2);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, push the expected
    // ID/EX contents, then pop and compare after the edge.
    task automatic step(input int kind, input logic [31:0] instr, input logic [31:0] pc,
                        input logic vld, input logic rdy, input logic fl, input logic rs,
                        input logic exp_rdy, input logic [3:0] op, input logic [31:0] imm,
                        input logic rw, input logic mr, input logic mw, input logic ill);
        exp_t e;
        exp_t got_e;
        @(negedge clk);
        rst          = rs;
        bus.if_valid = vld;
        bus.if_instr = instr;
        bus.if_pc    = pc;
        bus.ex_ready = rdy;
        bus.flush    = fl;
        #1;
        check_eq("if_ready", 32'(bus.if_ready), 32'(exp_rdy));
        check_eq("rf_raddr1", 32'(bus.rf_raddr1), 32'(instr[19:15]));
        check_eq("rf_raddr2", 32'(bus.rf_raddr2), 32'(instr[24:20]));
        e = '{valid: 1'b0, full: 1'b0, pc: '0, imm: '0, rs1v: '0, rs2v: '0, rd: '0,
              rs1: '0, rs2: '0, op: '0, f3: '0, f7: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, ill: 1'b0};
        case (kind)
            K_CAP: begin
                e.valid = 1'b1; e.full = 1'b1; e.pc = pc; e.imm = imm;
                e.rd = instr[11:7]; e.rs1 = instr[19:15]; e.rs2 = instr[24:20];
                e.rs1v = 32'hA000_0000 | 32'(instr[19:15]);
                e.rs2v = 32'hB000_0000 | 32'(instr[24:20]);
                e.op = op; e.f3 = instr[14:12]; e.f7 = instr[30];
                e.rw = rw; e.mr = mr; e.mw = mw; e.ill = ill;
            end
            K_HOLD: e = last_e;
            K_RST: begin e.full = 1'b1; e.pc = RST_PC; end
            default: ;
        endcase
        last_e = e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        check_eq("ex_valid", 32'(bus.ex_valid), 32'(got_e.valid));
        check_eq("ex_reg_write", 32'(bus.ex_reg_write), 32'(got_e.rw));
        check_eq("ex_mem_read", 32'(bus.ex_mem_read), 32'(got_e.mr));
        check_eq("ex_mem_write", 32'(bus.ex_mem_write), 32'(got_e.mw));
        if (got_e.full) begin
            check_eq("ex_pc", bus.ex_pc, got_e.pc);
            check_eq("ex_imm", bus.ex_imm, got_e.imm);
            check_eq("ex_rd", 32'(bus.ex_rd), 32'(got_e.rd));
            check_eq("ex_rs1", 32'(bus.ex_rs1), 32'(got_e.rs1));
            check_eq("ex_rs2", 32'(bus.ex_rs2), 32'(got_e.rs2));
            check_eq("ex_rs1_val", bus.ex_rs1_val, got_e.rs1v);
            check_eq("ex_rs2_val", bus.ex_rs2_val, got_e.rs2v);
            check_eq("ex_op", 32'(bus.ex_op), 32'(got_e.op));
            check_eq("ex_funct3", 32'(bus.ex_funct3), 32'(got_e.f3));
            check_eq("ex_funct7b5", 32'(bus.ex_funct7b5), 32'(got_e.f7));
            check_eq("ex_illegal", 32'(bus.ex_illegal), 32'(got_e.ill));
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b0;
        @(posedge clk);
        //    kind    instr         pc            vld  rdy  fl   rst  rdy? op          imm           rw   mr   mw   ill
        step(K_RST,  32'h0000_0000, 32'h0,       0,   1,   0,   1,   1,   OP,         32'h0,        0,   0,   0,   0);
        step(K_CAP,  32'h0050_0093, 32'h100,     1,   1,   0,   0,   1,   OP_IMM,     32'h5,        1,   0,   0,   0);
        step(K_CAP,  32'h0000_A103, 32'h104,     1,   1,   0,   0,   1,   LOAD,       32'h0,        1,   1,   0,   0);
        step(K_BUB,  32'h0011_01B3, 32'h108,     1,   1,   0,   0,   0,   OP,         32'h0,        0,   0,   0,   0);
        step(K_CAP,  32'h0011_01B3, 32'h108,     1,   1,   0,   0,   1,   OP,         32'h0,        1,   0,   0,   0);
        step(K_CAP,  32'hFE00_0CE3, 32'h10C,     1,   1,   0,   0,   1,   BRANCH,     32'hFFFF_FFF8,0,   0,   0,   0);
        step(K_CAP,  32'h0030_2223, 32'h110,     1,   1,   0,   0,   1,   STORE,      32'h4,        0,   0,   1,   0);
        for (int i = 0; i < 3; i++)
            step(K_HOLD, 32'h0070_8293, 32'h114, 1,   0,   0,   0,   0,   OP,         32'h0,        0,   0,   0,   0);
        step(K_CAP,  32'h0070_8293, 32'h114,     1,   1,   0,   0,   1,   OP_IMM,     32'h7,        1,   0,   0,   0);
        step(K_CAP,  32'h0082_A303, 32'h118,     1,   1,   0,   0,   1,   LOAD,       32'h8,        1,   1,   0,   0);
        step(K_BUB,  32'h0013_0393, 32'h11C,     1,   1,   1,   0,   1,   OP,         32'h0,        0,   0,   0,   0);
        step(K_CAP,  32'h0013_0393, 32'h140,     1,   1,   0,   0,   1,   OP_IMM,     32'h1,        1,   0,   0,   0);
        step(K_CAP,  32'h1234_5437, 32'h144,     1,   1,   0,   0,   1,   LUI,        32'h1234_5000,1,   0,   0,   0);
        step(K_CAP,  32'h0080_00EF, 32'h148,     1,   1,   0,   0,   1,   JAL,        32'h8,        1,   0,   0,   0);
        step(K_CAP,  32'h0000_A003, 32'h14C,     1,   1,   0,   0,   1,   LOAD,       32'h0,        0,   1,   0,   0);
        step(K_CAP,  32'h0000_01B3, 32'h150,     1,   1,   0,   0,   1,   OP,         32'h0,        1,   0,   0,   0);
        step(K_CAP,  32'h0000_007F, 32'h154,     1,   1,   0,   0,   1,   OP_ILLEGAL, 32'h0,        0,   0,   0,   1);
        step(K_RST,  32'h0050_0093, 32'h158,     1,   1,   0,   1,   1,   OP,         32'h0,        0,   0,   0,   0);
        step(K_BUB,  32'h0000_0000, 32'h15C,     0,   1,   0,   0,   1,   OP,         32'h0,        0,   0,   0,   0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
